// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the BRAM arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int DEF_NUM_REQ      = 2;
  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_READ_LATENCY = 2;

  // Ids are sized for the largest supported requester count so one type fits every instance.
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } stage_t;

endpackage

// File: rtl/rr_grant.sv
// Round-robin pick: first active request at or above rr_ptr, wrapping; rr_ptr moves past each winner.
module rr_grant
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_REQ-1:0] req,
  input  logic               fire,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            grant_idx
);

  req_id_t rr_ptr;
  logic    found;

  // NOTE: every output gets a default before the search, so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
          grant[i]  = 1'b1;
          grant_idx = req_id_t'(i);
          found     = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr <= '0;
    end else if (fire) begin
      rr_ptr <= (grant_idx == req_id_t'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency BRAM port; routes each response back to its issuer.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_wdata,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0]    req_wstrb,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_W-1:0]                   rsp_rdata,
  output logic                                mem_en,
  output logic [DATA_W/8-1:0]                 mem_we,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [DATA_W-1:0]                   mem_wdata,
  input  logic [DATA_W-1:0]                   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  req_id_t            grant_idx;
  logic               fire;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  stage_t             pipe [READ_LATENCY];

  // Nothing is granted while reset is asserted.
  assign req = req_valid & {NUM_REQ{~rst_in}};

  rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req       (req),
    .fire      (fire),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign fire      = |grant;
  assign req_ready = grant;
  assign mem_en    = fire;

  // One-hot grant steers the winner's payload; idle cycles replay the last address/data.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mem_addr  = req_addr[i];
        mem_wdata = req_wdata[i];
        mem_we    = req_we[i] ? req_wstrb[i] : {STRB_W{1'b0}};
      end
    end
  end

  // NOTE: the address/data hold registers are pure datapath and carry no reset.
  always_ff @(posedge clk_in) begin
    if (fire) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // Owner tracking shifts in lockstep with the BRAM read pipeline.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int s = 0; s < READ_LATENCY; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= '{valid: fire, id: grant_idx};
      for (int s = 1; s < READ_LATENCY; s++) pipe[s] <= pipe[s-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = pipe[READ_LATENCY-1].valid && (pipe[READ_LATENCY-1].id == req_id_t'(i));
    end
  end

  assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-by-cycle model comparison plus directed literal checks.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int SW = DW / 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  // Two-requester instance, checked every cycle against the model.
  logic [N-1:0]          req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [N-1:0][AW-1:0]  req_addr  = '0;
  logic [N-1:0][DW-1:0]  req_wdata = '0;
  logic [N-1:0][SW-1:0]  req_wstrb = '0;
  logic [DW-1:0]         rsp_rdata, mem_wdata, mem_rdata;
  logic                  mem_en;
  logic [SW-1:0]         mem_we;
  logic [AW-1:0]         mem_addr;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Three-requester instance for wrap-around and pointer-hold checks.
  logic [2:0]          v3 = '0, we3 = '0, rdy3, rsp3;
  logic [2:0][AW-1:0]  addr3  = '0;
  logic [2:0][DW-1:0]  wdata3 = '0;
  logic [2:0][SW-1:0]  wstrb3 = '0;
  logic [DW-1:0]       rdata3, mwdata3;
  logic [DW-1:0]       mrdata3 = '0;
  logic                men3;
  logic [SW-1:0]       mwe3;
  logic [AW-1:0]       maddr3;

  mem_arbiter #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut3 (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(v3), .req_ready(rdy3), .req_we(we3),
    .req_addr(addr3), .req_wdata(wdata3), .req_wstrb(wstrb3),
    .rsp_valid(rsp3), .rsp_rdata(rdata3),
    .mem_en(men3), .mem_we(mwe3), .mem_addr(maddr3),
    .mem_wdata(mwdata3), .mem_rdata(mrdata3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] init_word(input int a);
    case (a)
      4:       return 32'h1234_5678;
      8:       return 32'h0000_0000;
      16:      return 32'hDEAD_BEEF;
      default: return 32'hA500_0000 | DW'(a);
    endcase
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (strb[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Write-first BRAM with RL-cycle read latency.
  logic [DW-1:0] bram    [256];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
    end else if (mem_en) begin
      bram[mem_addr[7:0]]  <= merge(bram[mem_addr[7:0]], mem_wdata, mem_we);
      rd_pipe[0]           <= merge(bram[mem_addr[7:0]], mem_wdata, mem_we);
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RL-1];

  // Behavioural model: pointer, shadow memory and a queue of expected responses by due cycle.
  typedef struct {
    int            due;
    int            owner;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] shadow [256];
  int            m_ptr = 0;
  int            cyc   = 0;

  initial begin : compare
    int            win;
    logic [N-1:0]  exp_gnt, exp_rsp;
    logic [SW-1:0] exp_we;
    exp_t          e;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        check("rst_ready", req_ready, '0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_rsp", rsp_valid, '0);
        exp_q.delete();
        m_ptr = 0;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
      end else begin
        win = -1;
        for (int k = 0; k < N; k++)
          if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        exp_gnt = '0;
        if (win >= 0) exp_gnt[win] = 1'b1;
        check("grant", req_ready, exp_gnt);
        check("mem_en", mem_en, win >= 0);
        if (win >= 0) begin
          exp_we = req_we[win] ? req_wstrb[win] : '0;
          check("mem_addr", mem_addr, req_addr[win]);
          check("mem_we", mem_we, exp_we);
          if (req_we[win]) check("mem_wdata", mem_wdata, req_wdata[win]);
          shadow[req_addr[win][7:0]] = merge(shadow[req_addr[win][7:0]], req_wdata[win], exp_we);
          e.due = cyc + RL; e.owner = win; e.rd = !req_we[win]; e.data = shadow[req_addr[win][7:0]];
          exp_q.push_back(e);
          m_ptr = (win + 1) % N;
        end else begin
          check("mem_we_idle", mem_we, '0);
        end
        exp_rsp = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          exp_rsp[e.owner] = 1'b1;
          if (e.rd) check("rsp_rdata", rsp_rdata, e.data);
        end
        check("rsp_valid", rsp_valid, exp_rsp);
      end
      cyc++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin : stimulus
    logic [N-1:0] g;
    int cnt0, cnt1, first0, first1;

    step(); step();
    rst_in = 1'b0;

    // Single read from requester 0.
    req_valid = 2'b01; req_we = '0; req_addr[0] = 16'h0004;
    @(negedge clk_in);
    check("single_ready", req_ready, 2'b01);
    check("single_addr", mem_addr, 16'h0004);
    step(); req_valid = '0;
    @(negedge clk_in); check("single_no_early_rsp", rsp_valid, 2'b00);
    step();
    @(negedge clk_in);
    check("single_rsp", rsp_valid, 2'b01);
    check("single_data", rsp_rdata, 32'h1234_5678);
    step();

    // Reset while a read is in flight; requester 0 re-requests during reset.
    req_valid = 2'b01; req_addr[0] = 16'h0010;
    @(negedge clk_in); check("rstflight_fire", req_ready, 2'b01);
    step(); rst_in = 1'b1;
    @(negedge clk_in);
    check("rstflight_ready", req_ready, 2'b00);
    check("rstflight_mem_en", mem_en, 1'b0);
    step(); rst_in = 1'b0;
    @(negedge clk_in); check("rstflight_no_rsp_t2", rsp_valid, 2'b00);
    step(); req_valid = '0;
    @(negedge clk_in); check("rstflight_no_rsp_t3", rsp_valid, 2'b00);
    step();
    @(negedge clk_in);
    check("rstflight_new_rsp", rsp_valid, 2'b01);
    check("rstflight_new_data", rsp_rdata, 32'hDEAD_BEEF);
    step(); step();

    // Contention from reset: both requesters valid for six cycles.
    rst_in = 1'b1; step(); step();
    rst_in = 1'b0;
    req_valid = 2'b11; req_addr[0] = 16'h0000; req_addr[1] = 16'h0001;
    cnt0 = 0; cnt1 = 0; first0 = -1; first1 = -1;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) req_valid = '0;
      @(negedge clk_in);
      g = req_ready;
      if (c < 6) check("fair_grant", g, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (rsp_valid[0]) begin cnt0++; if (first0 < 0) first0 = c; end
      if (rsp_valid[1]) begin cnt1++; if (first1 < 0) first1 = c; end
      step();
    end
    check("fair_cnt0", cnt0, 3);
    check("fair_cnt1", cnt1, 3);
    check("fair_first0", first0, 2);
    check("fair_first1", first1, 3);

    // Byte-strobe write then read-back from requester 1.
    req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 16'h0008;
    req_wdata[1] = 32'hAABB_CCDD; req_wstrb[1] = 4'b0101;
    @(negedge clk_in);
    check("strb_ready", req_ready, 2'b10);
    check("strb_mem_we", mem_we, 4'b0101);
    step(); req_we = '0;
    @(negedge clk_in); check("strb_read_ready", req_ready, 2'b10);
    step(); req_valid = '0;
    @(negedge clk_in); check("strb_ack", rsp_valid, 2'b10);
    step();
    @(negedge clk_in);
    check("strb_read_rsp", rsp_valid, 2'b10);
    check("strb_read_data", rsp_rdata, 32'h00BB_00DD);
    step();

    // Back-to-back reads 0..3 from requester 0.
    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 4) ? 2'b01 : 2'b00;
      req_addr[0] = AW'(i);
      @(negedge clk_in);
      if (i < 4) check("b2b_ready", req_ready, 2'b01);
      if (i >= 2) begin
        check("b2b_rsp", rsp_valid, 2'b01);
        check("b2b_data", rsp_rdata, 32'hA500_0000 | DW'(i - 2));
      end
      step();
    end
    req_valid = '0;

    // Three requesters: wrap from 2 to 0, then pointer holds across idle cycles.
    v3 = 3'b010; addr3[1] = 16'h0021;
    @(negedge clk_in); check("wrap_g1", rdy3, 3'b010); check("wrap_a1", maddr3, 16'h0021);
    step(); v3 = 3'b101; addr3[0] = 16'h0030; addr3[2] = 16'h0032;
    @(negedge clk_in); check("wrap_g2", rdy3, 3'b100); check("wrap_a2", maddr3, 16'h0032);
    step(); v3 = 3'b001;
    @(negedge clk_in); check("wrap_g0", rdy3, 3'b001); check("wrap_a0", maddr3, 16'h0030);
    check("wrap_rsp1", rsp3, 3'b010);
    step(); v3 = 3'b000;
    @(negedge clk_in); check("idle_en", men3, 1'b0); check("idle_ready", rdy3, 3'b000);
    check("wrap_rsp2", rsp3, 3'b100);
    step();
    @(negedge clk_in); check("idle_en2", men3, 1'b0); check("idle_we", mwe3, 4'b0000);
    check("wrap_rsp0", rsp3, 3'b001);
    step(); v3 = 3'b110; addr3[1] = 16'h0041; addr3[2] = 16'h0042;
    @(negedge clk_in); check("hold_g1", rdy3, 3'b010); check("hold_a1", maddr3, 16'h0041);
    step(); v3 = 3'b100;
    @(negedge clk_in); check("hold_g2", rdy3, 3'b100);
    step(); v3 = 3'b000;

    step(); step(); step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency BRAM between NUM_REQ requesters, e.g. CPU instruction-fetch, CPU data and video/DMA.
- Sits between the cpu memory ports and the physical memory.
- Round-robin grant of one request per cycle; fully pipelined.
- Tracks the owner of each in-flight access and returns its response to that requester after exactly READ_LATENCY cycles.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 16, word-address width.
- DATA_W, 32, data width (multiple of 8).
- READ_LATENCY, 2, BRAM cycles from address to rdata (1..4).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  request present, per requester
- req_ready  out  NUM_REQ  request accepted this cycle (grant)
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ x ADDR_W  word address
- req_wdata  in  NUM_REQ x DATA_W  write data
- req_wstrb  in  NUM_REQ x DATA_W/8  byte enables for writes
- rsp_valid  out  NUM_REQ  response pulse, per requester
- rsp_rdata  out  DATA_W  read data, shared; meaningful when any rsp_valid is high
- mem_en  out  1  BRAM access enable
- mem_we  out  DATA_W/8  BRAM byte write enables
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data

Behaviour:
- Reset is asynchronous: rst_in high clears rr_ptr to 0, all pipeline valid bits to 0, and all rsp_valid to 0.
- req_ready, mem_en and mem_we are combinational and are 0 whenever no req_valid is high.
- Handshake:
  - A request fires when req_valid[i] && req_ready[i].
  - A requester holds valid and payload stable until fire.
  - req_valid must not depend on req_ready.
- Grant:
  - At most one bit of req_ready is high per cycle.
  - The winner is the first asserted req_valid scanning from index rr_ptr upward, modulo NUM_REQ.
  - Grant is combinational from req_valid and rr_ptr, with no bubble cycles.
- Pointer update: on fire by requester i, rr_ptr <= (i+1) mod NUM_REQ. With no fire, rr_ptr holds.
- Memory drive in a fire cycle:
  - mem_en = 1 and mem_addr = req_addr[winner].
  - mem_wdata = req_wdata[winner].
  - mem_we = req_we[winner] ? req_wstrb[winner] : 0.
  - In all other cycles mem_en = 0, mem_we = 0, and address/data are don't-care (hold last value).
- Response tracking:
  - A READ_LATENCY-deep shift register carries {valid, owner id} and advances every cycle.
  - Stage 0 is loaded on fire.
  - When the last stage is valid, rsp_valid[owner] = 1 for one cycle and rsp_rdata = mem_rdata.
  - Latency: a request firing in cycle T has its response in cycle T+READ_LATENCY. This holds for both reads and writes (a write response is an ack; rdata is don't-care).
- Throughput: one access per cycle sustained. Multiple accesses from the same or different requesters are in flight simultaneously, and responses return in issue order.
- Requesters cannot backpressure responses; they must sample rsp_valid/rsp_rdata unconditionally.
- Simultaneous events: a fire and a response in the same cycle, including to the same requester, are independent and both occur.
- Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0.
- Read-after-write: a read to an address written in an earlier cycle returns the new data. This relies on BRAM write-first or in-order behaviour; no forwarding is done in this block.
- Reset mid-operation: in-flight responses are discarded, and no rsp_valid fires after reset deasserts until a new request fires.

Decomposition:
- mem_arb_pkg holds:
  - the default widths;
  - typedef req_id_t (logic [$clog2(NUM_REQ)-1:0]);
  - the pipeline stage struct {valid, req_id_t id}.
- Sub-module rr_grant holds the combinational round-robin pick plus the rr_ptr register. Its ports are req vector, fire, grant one-hot, grant index.

Test Plan:
- Reset mid-flight: fire a read to addr 0x0010 (preloaded 0xDEADBEEF), then pulse rst_in at T+1 -> no rsp_valid at T+2; req_ready=0 and mem_en=0 during reset.
- Single read: requester 0 reads addr 0x0004, memory preloaded 0x12345678 -> req_ready[0]=1 at T, mem_addr=0x0004, rsp_valid[0]=1 at T+2 with rsp_rdata=0x12345678.
- Contention fairness: NUM_REQ=2, both valid continuously for 6 cycles from reset -> grants alternate 0,1,0,1,0,1; each rsp_valid pulses 3 times, at 2-cycle offset.
- Byte-strobe write: requester 1 writes 0xAABBCCDD with wstrb=4'b0101 to addr 0x0008 (preloaded 0), then reads it -> mem_we=4'b0101 on write, read returns 0x00BB00DD, and write ack rsp_valid[1] arrives at T+2.
- Back-to-back pipeline: requester 0 issues 4 reads to 0x0..0x3 on consecutive cycles, no other requesters -> 4 grants in 4 cycles; rsp_valid[0] high 4 consecutive cycles with data in address order.
- Wrap and idle: NUM_REQ=3, rr_ptr=2 after a requester-1 grant; requesters 0 and 2 both valid -> 2 granted, then 0; with all idle, rr_ptr holds and mem_en stays 0.
